// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 RGB444 capture path.
package cam_pkg;

   localparam int unsigned H_PIX_DEF = 160;
   localparam int unsigned V_PIX_DEF = 120;
   localparam int unsigned IMA_SIZE  = H_PIX_DEF * V_PIX_DEF;

   // Bit offsets of the 4-bit colour fields inside the 12-bit {R,G,B} word
   localparam int unsigned R_LSB = 8;
   localparam int unsigned G_LSB = 4;
   localparam int unsigned B_LSB = 0;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StWaitFrame = 3'd1,
      StByteHi    = 3'd2,
      StByteLo    = 3'd3,
      StDone      = 3'd4
   } cam_state_e;

   function automatic logic [11:0] pack_rgb444(input logic [3:0] r, input logic [3:0] g,
                                               input logic [3:0] b);
      logic [11:0] w;
      w              = '0;
      w[R_LSB +: 4]  = r;
      w[G_LSB +: 4]  = g;
      w[B_LSB +: 4]  = b;
      return w;
   endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Two-stage register for a camera sync input; level is the first stage,
// rise/fall pulses compare the two stages.
module cam_edge_det (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_s1;
   logic r_s2;

   // Shift the input through two flops
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_sig;
         r_s2 <= r_s1;
      end
   end

   assign o_level = r_s1;
   assign o_rise  = r_s1 & ~r_s2;
   assign o_fall  = ~r_s1 & r_s2;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 QQVGA RGB444 capture: pairs camera bytes into 12-bit pixels and
// drives the write port of the frame buffer (clocked by pclk).
module cam_capture_rgb444
   import cam_pkg::*;
#(
   parameter int unsigned AW    = 15,
   parameter int unsigned DW    = 12,
   parameter int unsigned H_PIX = H_PIX_DEF,
   parameter int unsigned V_PIX = V_PIX_DEF
) (
   input  logic          i_pclk,
   input  logic          i_reset,
   input  logic          i_capture_en,
   input  logic          i_vsync,
   input  logic          i_href,
   input  logic [7:0]    i_px_data,
   output logic [AW-1:0] o_mem_px_addr,
   output logic [DW-1:0] o_mem_px_data,
   output logic          o_px_wr,
   output logic          o_frame_done,
   output logic          o_busy
);

   localparam int unsigned ImaSize = H_PIX * V_PIX;
   localparam int unsigned ColW    = $clog2(H_PIX + 1);
   localparam int unsigned RowW    = $clog2(V_PIX + 1);

   localparam logic [ColW-1:0] ColMax   = ColW'(H_PIX);
   localparam logic [RowW-1:0] RowMax   = RowW'(V_PIX);
   localparam logic [AW-1:0]   AddrEnd  = AW'(ImaSize);
   localparam logic [AW-1:0]   AddrLast = AW'(ImaSize - 1);

   cam_state_e r_state;
   cam_state_e w_state_d;

   logic [7:0]      r_px_d;
   logic [3:0]      r_red;
   logic            r_px_wr;
   logic [DW-1:0]   r_data;
   logic [AW-1:0]   r_addr;
   logic [ColW-1:0] r_col;
   logic [RowW-1:0] r_row;

   logic w_vs_lvl, w_vs_rise, w_vs_fall;
   logic w_hr_lvl, w_hr_rise, w_hr_fall;
   logic w_href_ok;
   logic w_pix_take;
   logic w_wr_d;
   logic w_frame_start;

   cam_edge_det u_vsync_det (
      .i_clk   (i_pclk),
      .i_reset (i_reset),
      .i_sig   (i_vsync),
      .o_level (w_vs_lvl),
      .o_rise  (w_vs_rise),
      .o_fall  (w_vs_fall)
   );

   cam_edge_det u_href_det (
      .i_clk   (i_pclk),
      .i_reset (i_reset),
      .i_sig   (i_href),
      .o_level (w_hr_lvl),
      .o_rise  (w_hr_rise),
      .o_fall  (w_hr_fall)
   );

   // Bytes during vertical blanking are never pixel data
   assign w_href_ok = w_hr_lvl & ~w_vs_lvl;

   // State register
   always_ff @(posedge i_pclk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic and pixel-complete strobe
   always_comb begin
      w_state_d  = r_state;
      w_pix_take = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_capture_en) w_state_d = StWaitFrame;
         end
         StWaitFrame: begin
            if (!i_capture_en)  w_state_d = StIdle;
            else if (w_vs_fall) w_state_d = StByteHi;
         end
         StByteHi: begin
            if (w_vs_rise)      w_state_d = StIdle;
            else if (w_href_ok) w_state_d = StByteLo;
         end
         StByteLo: begin
            if (w_vs_rise) begin
               w_state_d = StIdle;
            end else if (w_href_ok) begin
               w_state_d  = StByteHi;
               w_pix_take = 1'b1;
            end else if (w_hr_fall) begin
               // Line ended on a high byte: drop the half pixel
               w_state_d = StByteHi;
            end
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
      // The write of the last pixel ends the frame, ahead of any abort
      if (o_busy && r_px_wr && (r_addr == AddrLast)) w_state_d = StDone;
   end

   assign w_frame_start = (r_state == StWaitFrame) && (w_state_d == StByteHi);
   assign w_wr_d        = w_pix_take && (r_col < ColMax) && (r_row < RowMax) &&
                          (r_addr < AddrEnd);

   // Byte pairing, line/column tracking and frame-buffer write port
   always_ff @(posedge i_pclk) begin
      if (i_reset) begin
         r_px_d  <= '0;
         r_red   <= '0;
         r_px_wr <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         r_px_d  <= i_px_data;
         r_px_wr <= w_wr_d;
         if (w_wr_d) r_data <= DW'(pack_rgb444(r_red, r_px_d[7:4], r_px_d[3:0]));
         if (r_state == StByteHi && w_href_ok && !w_vs_rise) r_red <= r_px_d[3:0];

         if (w_frame_start) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
         end else begin
            if (r_px_wr) r_addr <= r_addr + AW'(1);
            if (o_busy && w_hr_fall) begin
               r_col <= '0;
               if (r_row < RowMax) r_row <= r_row + RowW'(1);
            end else if (o_busy && w_hr_rise) begin
               // Also realign at line start in case a fall was masked by vsync
               r_col <= '0;
            end else if (w_pix_take && (r_col < ColMax)) begin
               r_col <= r_col + ColW'(1);
            end
         end
      end
   end

   assign o_mem_px_addr = r_addr;
   assign o_mem_px_data = r_data;
   assign o_px_wr       = r_px_wr;
   assign o_frame_done  = (r_state == StDone);
   assign o_busy        = (r_state == StByteHi) || (r_state == StByteLo);

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Scoreboard bench for cam_capture_rgb444: lines of random camera bytes are
// turned into expected frame-buffer writes by a per-line pixel model.
`timescale 1ns/1ps
module tb_cam_capture_rgb444;
   import cam_pkg::*;

   localparam int unsigned AW   = 15;
   localparam int unsigned DW   = 12;
   localparam int          HP   = 160;
   localparam int          NPIX = IMA_SIZE;

   logic          clk = 1'b0;
   logic          reset;
   logic          capture_en;
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [AW-1:0] mem_px_addr;
   logic [DW-1:0] mem_px_data;
   logic          px_wr;
   logic          frame_done;
   logic          busy;

   always #5 clk = ~clk;

   cam_capture_rgb444 #(
      .AW    (AW),
      .DW    (DW),
      .H_PIX (160),
      .V_PIX (120)
   ) dut (
      .i_pclk        (clk),
      .i_reset       (reset),
      .i_capture_en  (capture_en),
      .i_vsync       (vsync),
      .i_href        (href),
      .i_px_data     (px_data),
      .o_mem_px_addr (mem_px_addr),
      .o_mem_px_data (mem_px_data),
      .o_px_wr       (px_wr),
      .o_frame_done  (frame_done),
      .o_busy        (busy)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           mon_e;
   int            total = 0;
   int            bad = 0;
   bit            sb_on = 1'b0;
   bit            chk_inc = 1'b0;
   logic [AW-1:0] inc_exp;
   int            wr_count = 0;
   int            done_count = 0;
   int            last_wr_addr = -1;
   int            exp_addr = 0;
   int            exp_done = 0;
   bit            frame_active = 1'b0;

   task automatic check_eq(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every presented write is popped against the model queue
   always @(negedge clk) begin
      if (sb_on) begin
         if (chk_inc) check_eq("addr_after_wr", int'(mem_px_addr), int'(inc_exp));
         chk_inc = 1'b0;
         if (px_wr) begin
            wr_count++;
            last_wr_addr = int'(mem_px_addr);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_wr_addr", int'(mem_px_addr), -1);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("wr_addr", int'(mem_px_addr), int'(mon_e.addr));
               check_eq("wr_data", int'(mem_px_data), int'(mon_e.data));
            end
            chk_inc = 1'b1;
            inc_exp = mem_px_addr + AW'(1);
         end
         if (frame_done) done_count++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      vsync   = v;
      href    = h;
      px_data = d;
      tick();
   endtask

   // Vertical blanking then the falling vsync that starts a frame
   task automatic open_frame();
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      frame_active = capture_en;
      if (frame_active) exp_addr = 0;
      repeat (3) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic close_frame();
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      frame_active = 1'b0;
   endtask

   // One href line: byte pairs become pixels, at most HP per line, frame-clamped
   task automatic send_line(input int nbytes, input bit pix_is_addr);
      logic [7:0]  b[$];
      logic [11:0] a12;
      wr_t         e;
      int          npix;
      b = {};
      for (int k = 0; k < nbytes; k++) b.push_back(8'($urandom));
      npix = nbytes / 2;
      if (npix > HP) npix = HP;
      for (int k = 0; k < npix; k++) begin
         if (frame_active && exp_addr < NPIX) begin
            if (pix_is_addr) begin
               a12        = 12'(exp_addr);
               b[2*k]     = {b[2*k][7:4], a12[11:8]};
               b[2*k + 1] = a12[7:0];
            end
            e.addr = AW'(exp_addr);
            e.data = {b[2*k][3:0], b[2*k + 1]};
            exp_q.push_back(e);
            exp_addr++;
            if (exp_addr == NPIX) begin
               exp_done++;
               frame_active = 1'b0;
            end
         end
      end
      for (int k = 0; k < nbytes; k++) drive(1'b0, 1'b1, b[k]);
      repeat ($urandom_range(2, 6)) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check_eq(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int wr0;
      int done0;
      wr_t e;

      reset = 1'b1; capture_en = 1'b1; vsync = 1'b1; href = 1'b0; px_data = 8'h00;
      repeat (4) tick();
      @(negedge clk);
      check_eq("rst_px_wr", int'(px_wr), 0);
      check_eq("rst_addr", int'(mem_px_addr), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_frame_done", int'(frame_done), 0);
      check_eq("rst_data", int'(mem_px_data), 0);
      tick();
      reset = 1'b0;

      // Start a frame, then reset in the middle of a line
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 8'($urandom));
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 8'($urandom));
         check_eq("midrst_px_wr", int'(px_wr), 0);
         check_eq("midrst_addr", int'(mem_px_addr), 0);
         check_eq("midrst_busy", int'(busy), 0);
      end
      reset   = 1'b0;
      chk_inc = 1'b0;
      sb_on   = 1'b1;
      // Lines without a new vsync fall must produce no writes
      wr0 = wr_count;
      for (int l = 0; l < 3; l++) send_line(40, 1'b0);
      check_eq("no_wr_before_vsync", wr_count - wr0, 0);
      check_eq("no_busy_before_vsync", int'(busy), 0);

      // Single pixel 0x0A, 0xBC
      open_frame();
      wr0 = wr_count; done0 = done_count;
      e.addr = '0; e.data = 12'hABC;
      exp_q.push_back(e);
      drive(1'b0, 1'b1, 8'h0A);
      drive(1'b0, 1'b1, 8'hBC);
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      check_eq("one_px_count", wr_count - wr0, 1);
      check_eq("one_px_last_addr", last_wr_addr, 0);
      check_eq("one_px_addr_next", int'(mem_px_addr), 1);
      check_eq("one_px_busy", int'(busy), 1);
      close_frame();
      drain("one_px_drain");
      check_eq("one_px_abort_busy", int'(busy), 0);
      check_eq("one_px_no_done", done_count - done0, 0);

      // Short frame: vsync rises after 50 lines
      open_frame();
      wr0 = wr_count; done0 = done_count;
      for (int l = 0; l < 50; l++) send_line(320, 1'b0);
      close_frame();
      drain("short_drain");
      check_eq("short_count", wr_count - wr0, 50 * HP);
      check_eq("short_last_addr", last_wr_addr, 50 * HP - 1);
      check_eq("short_no_done", done_count - done0, 0);
      check_eq("short_busy", int'(busy), 0);

      // Full frame, one 321-byte line, capture_en dropped partway through
      open_frame();
      wr0 = wr_count; done0 = done_count; exp_done = 0;
      for (int l = 0; l < 120; l++) begin
         if (l == 60) begin
            capture_en = 1'b0;
            check_eq("full_busy_mid", int'(busy), 1);
         end
         send_line((l == 5) ? 321 : 320, 1'b1);
      end
      close_frame();
      drain("full_drain");
      check_eq("full_count", wr_count - wr0, NPIX);
      check_eq("full_last_addr", last_wr_addr, NPIX - 1);
      check_eq("full_done", done_count - done0, exp_done);
      check_eq("full_addr_hold", int'(mem_px_addr), NPIX);
      check_eq("full_busy_end", int'(busy), 0);

      // Next frame with capture disabled: nothing written
      open_frame();
      wr0 = wr_count; done0 = done_count;
      for (int l = 0; l < 3; l++) send_line(320, 1'b0);
      close_frame();
      drain("off_drain");
      check_eq("off_count", wr_count - wr0, 0);
      check_eq("off_done", done_count - done0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
